// File: rtl/fu_result_collect_if.sv
// fu_result_collect_if
// Bundles the functional-unit result channels, the selection controls and the
// writeback handshake into one interface.
//   master : functional units + decode + downstream (drives requests, mode/sel,
//            wb_ready; observes res_ready and the writeback bus)
//   slave  : the result collector itself
// Signals:
//   mode      0 = directed select by sel, 1 = round-robin arbitration
//   sel       channel index used in directed mode
//   res_data  N*W packed channel data, channel i at [i*W +: W]
//   res_valid per-channel result valid
//   res_ready per-channel accept (combinational from the collector)
//   wb_data   registered writeback data
//   wb_src    channel index that produced wb_data
//   wb_valid  writeback data valid
//   wb_ready  downstream accepts wb_data
interface fu_result_collect_if #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  res_data;
    logic [N-1:0]    res_valid;
    logic [N-1:0]    res_ready;
    logic [W-1:0]    wb_data;
    logic [SW-1:0]   wb_src;
    logic            wb_valid;
    logic            wb_ready;

    modport master (
        output mode, sel, res_data, res_valid, wb_ready,
        input  res_ready, wb_data, wb_src, wb_valid
    );

    modport slave (
        input  mode, sel, res_data, res_valid, wb_ready,
        output res_ready, wb_data, wb_src, wb_valid
    );
endinterface

// File: rtl/fu_result_collect.sv
// fu_result_collect
// Collects results from N functional-unit channels onto one registered W-bit
// writeback path. A channel is picked either by the decode-supplied index
// (mode=0) or by round-robin arbitration starting at rr_ptr (mode=1). One
// output register sits on the writeback path; it is reloaded whenever it is
// empty or being drained, so a continuously ready sink sees one result per
// cycle. stall_cnt counts, saturating, the cycles in which some channel was
// requesting but nothing transferred.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       fu_result_collect_if.slave (channels, mode/sel, writeback)
//   stall_cnt saturating stalled-request cycle count
module fu_result_collect #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = 2,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    fu_result_collect_if.slave  bus,
    output logic [CW-1:0]       stall_cnt
);

    localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};
    localparam logic [SW-1:0] LAST_IDX  = SW'(N - 1);

    logic [W-1:0]  wb_data_reg;
    logic [SW-1:0] wb_src_reg;
    logic          wb_valid_reg;
    logic [SW-1:0] rr_ptr_reg;
    logic [CW-1:0] stall_cnt_reg;

    logic [W-1:0]  ch_data [N];
    logic          load_en;
    logic          grant_any;
    logic [SW-1:0] grant_idx;
    logic          xfer;
    logic [SW-1:0] rr_next;

    // Unpack the flat channel bus and form the one-hot accept vector.
    // res_ready is gated by rst so nothing is acknowledged while in reset.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            assign ch_data[gi]       = bus.res_data[gi*W +: W];
            assign bus.res_ready[gi] = ~rst & xfer & (grant_idx == SW'(gi));
        end
    endgenerate

    // Output register can take a new result when empty or being drained.
    assign load_en = ~wb_valid_reg | bus.wb_ready;
    assign xfer    = load_en & grant_any;

    // Grant selection. Directed mode only ever considers the selected channel;
    // an out-of-range index grants nothing. Round-robin scans from rr_ptr
    // upward with wraparound and takes the first valid channel.
    always_comb begin
        int            scan_int;
        logic [SW-1:0] scan_idx;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_int  = 0;
        scan_idx  = '0;
        if (!bus.mode) begin
            if ((32'(bus.sel) < N) && bus.res_valid[bus.sel]) begin
                grant_any = 1'b1;
                grant_idx = bus.sel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_int = (int'(rr_ptr_reg) + k) % N;
                scan_idx = SW'(scan_int);
                if (!grant_any && bus.res_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    // Pointer moves to the channel after the winner so it gets lowest priority.
    assign rr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_reg   <= '0;
            wb_src_reg    <= '0;
            wb_valid_reg  <= 1'b0;
            rr_ptr_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (xfer) begin
                wb_data_reg  <= ch_data[grant_idx];
                wb_src_reg   <= grant_idx;
                wb_valid_reg <= 1'b1;
                if (bus.mode) begin
                    rr_ptr_reg <= rr_next;
                end
            end else if (wb_valid_reg && bus.wb_ready) begin
                // Drain without reload: data and source keep their last values.
                wb_valid_reg <= 1'b0;
            end

            if ((|bus.res_valid) && !xfer && (stall_cnt_reg != STALL_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + CW'(1);
            end
        end
    end

    assign bus.wb_data  = wb_data_reg;
    assign bus.wb_src   = wb_src_reg;
    assign bus.wb_valid = wb_valid_reg;
    assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_fu_result_collect.sv
module tb_fu_result_collect;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int CW = 8;
    localparam int SMAX = 255;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] stall_cnt;

    fu_result_collect_if #(.W(W), .N(N), .SW(SW)) bus ();

    fu_result_collect #(.W(W), .N(N), .SW(SW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference: contents of the output register, arbitration
    // pointer and stall count, advanced one clock at a time.
    int          m_v;
    logic [15:0] m_d;
    int          m_src;
    int          m_rr;
    int          m_stall;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       wbr;
        logic [3:0] exp_ready;
        logic       exp_wbv;
        logic [1:0] exp_src;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic mreset();
        m_v = 0; m_d = '0; m_src = 0; m_rr = 0; m_stall = 0;
    endtask

    function automatic int mgrant();
        if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < N && bus.res_valid[bus.sel]) return int'(bus.sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int idx = (m_rr + k) % N;
            if (bus.res_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic cycle(input string tag);
        int g;
        bit le;
        logic [3:0] er;
        logic [15:0] gd;
        #2;
        g  = mgrant();
        le = (m_v == 0) || bus.wb_ready;
        er = (le && g >= 0) ? 4'(1 << g) : 4'b0000;
        gd = (g >= 0) ? bus.res_data[g*W +: W] : 16'h0;
        chk({tag, " res_ready"}, 32'(bus.res_ready), 32'(er));
        @(posedge clk);
        if (le && g >= 0) begin
            m_v = 1; m_d = gd; m_src = g;
            if (bus.mode) m_rr = (g + 1) % N;
            $display("[%0t] %s: transfer src=%0d data=%h", $time, tag, g, gd);
        end else begin
            if (m_v != 0 && bus.wb_ready) m_v = 0;
            $display("[%0t] %s: no transfer", $time, tag);
        end
        if (bus.res_valid != 0 && !(le && g >= 0) && m_stall < SMAX) m_stall++;
        #1;
        chk({tag, " wb_valid"},  32'(bus.wb_valid), 32'(m_v));
        chk({tag, " wb_src"},    32'(bus.wb_src),   32'(m_src));
        chk({tag, " wb_data"},   32'(bus.wb_data),  32'(m_d));
        chk({tag, " stall_cnt"}, 32'(stall_cnt),    32'(m_stall));
    endtask

    task automatic drive(input logic md, input logic [1:0] s, input logic [3:0] v, input logic wr);
        bus.mode = md; bus.sel = s; bus.res_valid = v; bus.wb_ready = wr;
    endtask

    initial begin
        logic [15:0] held;
        int          st_before;

        // Directed table, starting from the post-reset state (rr=0, empty).
        vecs[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[10] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[11] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[12] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[13] = '{1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[14] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[15] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset with every channel requesting.
        rst = 1'b1;
        bus.res_data = {16'h3C3C, 16'hA5A5, 16'h2222, 16'h1111};
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst wb_valid",  32'(bus.wb_valid),  32'd0);
        chk("rst wb_data",   32'(bus.wb_data),   32'd0);
        chk("rst res_ready", 32'(bus.res_ready), 32'd0);
        chk("rst stall_cnt", 32'(stall_cnt),     32'd0);
        rst = 1'b0;
        mreset();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].wbr);
            #2;
            chk($sformatf("vec%0d ready", i), 32'(bus.res_ready), 32'(vecs[i].exp_ready));
            #2;
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d wbv", i), 32'(bus.wb_valid), 32'(vecs[i].exp_wbv));
            chk($sformatf("vec%0d src", i), 32'(bus.wb_src),   32'(vecs[i].exp_src));
        end

        // Backpressure: fill the output, then hold it for 5 cycles.
        drive(1'b1, 2'd0, 4'b0001, 1'b1);
        cycle("bp_fill");
        held = bus.res_data[15:0];
        st_before = m_stall;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, 4'b0001, 1'b0);
            bus.res_data = {$urandom, $urandom};
            cycle("bp_hold");
        end
        chk("bp data stable", 32'(bus.wb_data), 32'(held));
        chk("bp stall+5",     32'(stall_cnt),   32'(st_before + 5));
        // Release: drain and reload on the same edge.
        bus.res_data = {16'h0, 16'h0, 16'h0, 16'h5EED};
        drive(1'b1, 2'd0, 4'b0001, 1'b1);
        cycle("bp_release");
        chk("bp no bubble valid", 32'(bus.wb_valid), 32'd1);
        chk("bp no bubble data",  32'(bus.wb_data),  32'h5EED);

        // Saturation: output blocked with a pending request for 300 cycles.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd0, 4'b0001, 1'b0);
            cycle("sat");
        end
        chk("sat stall_cnt", 32'(stall_cnt), 32'd255);

        // Async reset between edges while the output holds data.
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst wb_valid",  32'(bus.wb_valid),  32'd0);
        chk("arst wb_data",   32'(bus.wb_data),   32'd0);
        chk("arst res_ready", 32'(bus.res_ready), 32'd0);
        chk("arst stall_cnt", 32'(stall_cnt),     32'd0);
        mreset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 2'd0, 4'b0110, 1'b1);
        cycle("post_rst");
        chk("post_rst lowest src", 32'(bus.wb_src), 32'd1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            bus.res_data  = {$urandom, $urandom};
            bus.mode      = 1'($urandom_range(0, 1));
            bus.sel       = 2'($urandom_range(0, 3));
            bus.res_valid = 4'($urandom_range(0, 15));
            bus.wb_ready  = ($urandom_range(0, 3) != 0);
            cycle($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fu_result_collect.md
Name: fu_result_collect

Overview:
- Parametrised, registered successor to the gate-level functional-unit output mux.
- Collects results from N functional units (ALU, shifter, multiplier, etc.) onto one W-bit writeback path toward the register file.
- Each functional-unit channel uses a valid/ready handshake.
- Two selection modes: decode-directed select, or round-robin arbitration.
- One pipeline register on the output; saturating stall counter for performance debug.

Parameters:
- W, 16, data width of each result and of the writeback bus.
- N, 4, number of functional-unit channels (2..16).
- SW, 2, select/source index width; must equal ceil(log2(N)), minimum 1.
- CW, 8, width of the stall counter.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- mode, input, 1, 0 = directed select by sel; 1 = round-robin arbitration.
- sel, input, SW, channel index used when mode=0.
- res_data, input, N*W, channel i occupies bits [i*W +: W].
- res_valid, input, N, per-channel result valid.
- res_ready, output, N, per-channel accept; combinational.
- wb_data, output, W, registered writeback data.
- wb_src, output, SW, index of the channel that produced wb_data.
- wb_valid, output, 1, writeback data valid.
- wb_ready, input, 1, downstream accepts wb_data.
- stall_cnt, output, CW, saturating count of stalled-request cycles.

Behaviour:
- Reset (async, rst=1): wb_valid=0, wb_data=0, wb_src=0, rr_ptr=0, stall_cnt=0.
  - All res_ready forced to 0 while rst=1.
- load_en = ~wb_valid | wb_ready, i.e. the output register is empty or is being drained this cycle.
- Grant, mode=0:
  - g = sel, granted only if sel < N and res_valid[sel]=1.
  - sel >= N grants nothing.
  - Other valid channels are never accepted.
- Grant, mode=1:
  - g = first i with res_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N.
  - No valid channel means no grant.
- res_ready[i] = load_en & grant[i]; at most one bit set per cycle.
- Transfer edge (load_en & any grant):
  - wb_data <= res_data[g], wb_src <= g, wb_valid <= 1.
  - If mode=1: rr_ptr <= (g+1) mod N.
- Drain only (wb_valid & wb_ready, no grant): wb_valid <= 0.
  - wb_data and wb_src hold their last values.
- Hold (wb_valid & ~wb_ready): wb_data, wb_src and wb_valid stable; all res_ready=0.
- Latency: 1 cycle from accepted res_valid to wb_valid.
- Throughput: 1 result/cycle when wb_ready is held high (simultaneous drain and load).
- rr_ptr:
  - Unchanged on cycles with no transfer.
  - Unchanged in mode=0.
  - Retained across mode switches; mode and sel are sampled every cycle with no pipeline flush.
- stall_cnt increments by 1 on every cycle where |res_valid=1 and no channel transfers.
  - Covers both a blocked output and mode=0 selecting a non-valid channel.
  - Saturates at 2^CW-1.
  - Cleared only by rst.
- Reset asserted mid-transfer: the output register clears immediately and the in-flight result is lost.
  - Upstream sees res_ready=0 for the duration of rst, so nothing is acknowledged.
- Channel data must be stable only during the cycle it is accepted; the block does not buffer unaccepted channels.

Test Plan:
- Reset: rst=1 with all res_valid=1 -> wb_valid=0, wb_data=0, res_ready=0, stall_cnt=0. Release rst with mode=1, wb_ready=1 -> next edge wb_src=0.
- Directed select, mode=0:
  - sel=2, res_valid=4'b1111, channel 2 data=16'hA5A5, wb_ready=1 -> res_ready=4'b0100; next cycle wb_data=16'hA5A5, wb_src=2.
  - Then sel=3 with res_valid[3]=0 -> no transfer and stall_cnt increments.
- Round-robin, mode=1: res_valid=4'b1111 held, wb_ready=1 for 8 cycles -> wb_src sequence 0,1,2,3,0,1,2,3, one result per cycle.
  - Then res_valid=4'b1010 -> alternating 1,3.
- Backpressure: wb_valid=1, wb_ready=0 for 5 cycles with res_valid=4'b0001 -> wb_data stable, res_ready=0, stall_cnt+5.
  - Raise wb_ready -> drain and load on the same edge, no bubble.
- Saturation: CW=8, block output for 300 cycles with requests pending -> stall_cnt=255 and held.
- Async reset mid-stream: assert rst between clock edges while wb_valid=1 -> wb_valid drops immediately, rr_ptr=0 after release, first grant goes to the lowest valid index.
